window_gen_55: RTL



---
 rtl/bnn_pkg.sv | 11 +
 rtl/window_gen_55_line_buffer.sv | 26 ++
 rtl/window_gen_55.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared window geometry for the 5x5 window generator and conv engine
package bnn_pkg;

    localparam int WIN_K     = 5;
    localparam int WIN_ELEMS = WIN_K * WIN_K;

    function automatic int win_idx(input int row, input int col);
        return row * WIN_K + col;
    endfunction

endpackage

// File: rtl/window_gen_55_line_buffer.sv
// rtl/window_gen_55_line_buffer.sv - one image line of storage, read-old-then-write at a shared column address
module line_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 28,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // The displaced entry is read in the same cycle it is overwritten, so the
    // cascade into the next-older line sees the previous row's pixel.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/window_gen_55.sv
// rtl/window_gen_55.sv - streaming 5x5 valid-padding window generator
// Optional downstream handshake (win_ready) enabled by WINDOW_GEN_BACKPRESSURE_EN.
module window_gen_55
    import bnn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pix_valid,
    input  logic                            pix_sof,
    input  logic [DATA_WIDTH-1:0]           pix_data,
    output logic                            pix_ready,
`ifdef WINDOW_GEN_BACKPRESSURE_EN
    input  logic                            win_ready,
`endif
    output logic                            win_valid,
    output logic [WIN_ELEMS*DATA_WIDTH-1:0] win_data,
    output logic                            frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NLB = WIN_K - 1;

    logic [CW-1:0]         col_q, col_d, cur_col;
    logic [RW-1:0]         row_q, row_d, cur_row;
    logic                  accept, wr_en, last_col, last_row, emit;
    logic                  win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] lb_rd   [NLB];
    logic [DATA_WIDTH-1:0] lb_wd   [NLB];
    logic [DATA_WIDTH-1:0] new_col [WIN_K];
    logic [DATA_WIDTH-1:0] win_q   [WIN_K][WIN_K];

    assign accept = pix_valid & pix_ready;
    assign wr_en  = accept & ~rst;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        cur_col  = pix_sof ? '0 : col_q;
        cur_row  = pix_sof ? '0 : row_q;
        last_col = (cur_col == CW'(IMG_W - 1));
        last_row = (cur_row == RW'(IMG_H - 1));
        col_d    = last_col ? '0 : cur_col + 1'b1;
        row_d    = last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
        emit     = accept && (cur_row >= RW'(NLB)) && (cur_col >= CW'(NLB));
    end

    // Line 3 holds the previous row, line 0 the row four above the current one.
    always_comb begin
        lb_wd[NLB-1] = pix_data;
        for (int i = 0; i < NLB - 1; i++) begin
            lb_wd[i] = lb_rd[i+1];
        end
        for (int i = 0; i < NLB; i++) begin
            new_col[i] = lb_rd[i];
        end
        new_col[WIN_K-1] = pix_data;
    end

    for (genvar i = 0; i < NLB; i++) begin : g_lb
        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (IMG_W),
            .AW         (CW)
        ) u_lb (
            .clk_i   (clk),
            .we_i    (wr_en),
            .addr_i  (cur_col),
            .wdata_i (lb_wd[i]),
            .rdata_o (lb_rd[i])
        );
    end

`ifdef WINDOW_GEN_BACKPRESSURE_EN
    assign pix_ready = ~win_valid_q | win_ready;

    always_comb begin
        win_valid_d  = accept ? emit : (win_valid_q & ~win_ready);
        frame_done_d = accept ? (emit & last_row & last_col) : (frame_done_q & ~win_ready);
    end
`else
    assign pix_ready = 1'b1;

    always_comb begin
        win_valid_d  = emit;
        frame_done_d = emit & last_row & last_col;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (accept) begin
                col_q <= col_d;
                row_q <= row_d;
            end
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < WIN_K; r++) begin
                for (int c = 0; c < WIN_K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < WIN_K; r++) begin
                for (int c = 0; c < WIN_K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][WIN_K-1] <= new_col[r];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K; c++) begin
                win_data[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
            end
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule
